// File: rtl/mult_pkg.sv
// Shared types and widths for the multiplier datapath: word/product widths,
// the MUL/MULH word select and the final CPA stage-1 payload.
package mult_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic {
    SEL_LO = 1'b0,
    SEL_HI = 1'b1
  } mult_sel_e;

  // Upper operands and the low partial sum are right-aligned in full-width
  // fields so the struct does not depend on the split position.
  typedef struct packed {
    logic [PROD_W-1:0] lo;
    logic              c1;
    logic [PROD_W-1:0] sum_hi;
    logic [PROD_W-1:0] carry_hi;
    mult_sel_e         sel;
  } mult_cpa_s1_t;

  function automatic logic [MULT_W-1:0] mult_pick_word(
    input logic [PROD_W-1:0] p,
    input mult_sel_e         sel
  );
    mult_pick_word = (sel == SEL_HI) ? p[PROD_W-1:MULT_W] : p[MULT_W-1:0];
  endfunction

endpackage

// File: rtl/mult_cpa_add.sv
// N-bit behavioural adder with carry-in and carry-out; one instance per
// pipeline stage of the final carry-propagate adder.
module mult_cpa_add #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  assign o_sum  = w_full[N-1:0];
  assign o_cout = w_full[N];

endmodule

// File: rtl/mult_final_cpa.sv
// Final carry-propagate stage of the tree multiplier: resolves sum/carry into
// a 64-bit product over two pipeline stages and returns the selected 32-bit
// word. Define MULT_FINAL_CPA_FULL64_EN to also expose the full product on product_o.
module mult_final_cpa
  import mult_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int SPLIT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PROD_W-1:0] sum_i,
  input  logic [PROD_W-1:0] carry_i,
  input  logic              sel_high_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MULT_W-1:0] result_o,
`ifdef MULT_FINAL_CPA_FULL64_EN
  output logic [PROD_W-1:0] product_o,
`endif
  output logic [TAG_W-1:0]  tag_o
);

  localparam int HI_W = PROD_W - SPLIT;

  logic              r_s1_valid;
  mult_cpa_s1_t      r_s1;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_out_valid;
  logic [MULT_W-1:0] r_result;
  logic [TAG_W-1:0]  r_tag;

  logic              w_s2_adv;
  logic              w_accept;
  logic [SPLIT-1:0]  w_lo;
  logic              w_c1;
  logic [HI_W-1:0]   w_hi;
  logic [PROD_W-1:0] w_p;
  mult_cpa_s1_t      w_s1_d;
  logic              w_unused;

  assign w_s2_adv   = r_s1_valid && (!r_out_valid || out_ready_i);
  assign in_ready_o = !r_s1_valid || w_s2_adv;
  assign w_accept   = in_valid_i && in_ready_o;

  // Stage 1: low slice of the product plus its carry-out.
  mult_cpa_add #(.N(SPLIT)) u_add_lo (
    .i_a    (sum_i[SPLIT-1:0]),
    .i_b    ({carry_i[SPLIT-2:0], 1'b0}),
    .i_cin  (1'b0),
    .o_sum  (w_lo),
    .o_cout (w_c1)
  );

  always_comb begin
    w_s1_d          = '0;
    w_s1_d.lo       = {{(PROD_W-SPLIT){1'b0}}, w_lo};
    w_s1_d.c1       = w_c1;
    w_s1_d.sum_hi   = {{SPLIT{1'b0}}, sum_i[PROD_W-1:SPLIT]};
    w_s1_d.carry_hi = {{SPLIT{1'b0}}, carry_i[PROD_W-2:SPLIT-1]};
    w_s1_d.sel      = mult_sel_e'(sel_high_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s1_tag   <= '0;
    end else begin
      if (flush_i) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_accept) begin
        r_s1     <= w_s1_d;
        r_s1_tag <= tag_i;
      end
    end
  end

  // Stage 2: upper slice absorbs the stage-1 carry, then word select.
  mult_cpa_add #(.N(HI_W)) u_add_hi (
    .i_a    (r_s1.sum_hi[HI_W-1:0]),
    .i_b    (r_s1.carry_hi[HI_W-1:0]),
    .i_cin  (r_s1.c1),
    .o_sum  (w_hi),
    .o_cout ()
  );

  assign w_p = {w_hi, r_s1.lo[SPLIT-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag       <= '0;
    end else begin
      if (flush_i) begin
        r_out_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_out_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_s2_adv) begin
        r_result <= mult_pick_word(w_p, r_s1.sel);
        r_tag    <= r_s1_tag;
      end
    end
  end

`ifdef MULT_FINAL_CPA_FULL64_EN
  logic [PROD_W-1:0] r_product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product <= '0;
    end else if (w_s2_adv) begin
      r_product <= w_p;
    end
  end

  assign product_o = r_product;
`endif

  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign tag_o       = r_tag;

  // Zero-extension padding in the payload and carry_i[63] carry no weight.
  assign w_unused = ^{carry_i[PROD_W-1], r_s1.lo[PROD_W-1:SPLIT],
                      r_s1.sum_hi[PROD_W-1:HI_W], r_s1.carry_hi[PROD_W-1:HI_W]};

endmodule

// File: tb/tb_mult_final_cpa.sv
// Self-checking bench for mult_final_cpa: directed vectors, back-pressure,
// flush, asynchronous reset and a random stream against a queue-based model.
module tb_mult_final_cpa;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] sum_i;
  logic [63:0] carry_i;
  logic        sel_high_i;
  logic [4:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  tag_o;
`ifdef MULT_FINAL_CPA_FULL64_EN
  logic [63:0] product_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  typedef struct {
    logic [63:0] p;
    logic        sel;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];

  mult_final_cpa #(.TAG_W(5), .SPLIT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_i       (sum_i),
    .carry_i     (carry_i),
    .sel_high_i  (sel_high_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
`ifdef MULT_FINAL_CPA_FULL64_EN
    .product_o   (product_o),
`endif
    .tag_o       (tag_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_p(input logic [63:0] s, input logic [63:0] c);
    model_p = s + (c << 1);
  endfunction

  function automatic logic [31:0] model_word(input logic [63:0] p, input logic sh);
    model_word = sh ? p[63:32] : p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model bookkeeping on the active edge (old values visible in active region).
  always @(posedge rst) q.delete();

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        hs_count++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (flush_i) begin
        q.delete();
      end else if (in_valid_i && in_ready_o) begin
        exp_t e;
        e.p   = model_p(sum_i, carry_i);
        e.sel = sel_high_i;
        e.tag = tag_i;
        q.push_back(e);
      end
    end
  end

  // Compare process: every cycle outputs are meaningful.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("in_ready", {63'd0, in_ready_o}, {63'd0, (q.size() < 2) || out_ready_i});
      if (out_valid_o) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", {63'd0, out_valid_o}, 64'd0);
        end else begin
          check("result", {32'd0, result_o}, {32'd0, model_word(q[0].p, q[0].sel)});
          check("tag", {59'd0, tag_o}, {59'd0, q[0].tag});
`ifdef MULT_FINAL_CPA_FULL64_EN
          check("product", product_o, q[0].p);
`endif
        end
      end
    end
  end

  task automatic send(input logic [63:0] s, input logic [63:0] c, input logic sh,
                      input logic [4:0] t);
    int   budget;
    logic rdy;
    sum_i = s; carry_i = c; sel_high_i = sh; tag_i = t; in_valid_i = 1'b1;
    budget = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready_o;
      @(posedge clk);
      if (rdy) break;
      budget++;
      if (budget > 50) begin
        check("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    #1 in_valid_i = 1'b0;
  endtask

  // Accept, then exactly two edges to a valid result with out_ready held high.
  task automatic do_op(input string name, input logic [63:0] s, input logic [63:0] c,
                       input logic sh, input logic [4:0] t, input logic [31:0] exp_r);
    send(s, c, sh, t);
    check({name, "_lat1"}, {63'd0, out_valid_o}, 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, {63'd0, out_valid_o}, 64'd1);
    check({name, "_result"}, {32'd0, result_o}, {32'd0, exp_r});
    check({name, "_tag"}, {59'd0, tag_o}, {59'd0, t});
  endtask

  initial begin
    logic [31:0] held;
    int          hs0;
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    sum_i = '0; carry_i = '0; sel_high_i = 1'b0; tag_i = '0;

    check("model_pin_basic", {32'd0, model_word(model_p(64'h3, 64'h1), 1'b0)}, 64'h5);
    check("model_pin_wrap", model_p(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001), 64'h1);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_result", {32'd0, result_o}, 64'd0);
    check("rst_tag", {59'd0, tag_o}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
`ifdef MULT_FINAL_CPA_FULL64_EN
    check("rst_product", product_o, 64'd0);
`endif
    @(posedge clk); #1;

    do_op("basic_lo", 64'h3, 64'h1, 1'b0, 5'd7, 32'h5);
    do_op("split_hi", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b1, 5'd9, 32'h1);
`ifdef MULT_FINAL_CPA_FULL64_EN
    check("split_product", product_o, 64'h1_0000_0001);
`endif
    do_op("split_lo", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 5'd10, 32'h1);
    do_op("wrap_hi", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b1, 5'd31, 32'h0);
    do_op("wrap_lo", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 5'd30, 32'h1);
    @(posedge clk); #1;

    // Back-pressure: four ops against a stalled consumer for five edges.
    out_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(64'h1000 * (i + 1), 64'h10 + i, i[0], 5'(i + 1));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        check("bp_ready_low", {63'd0, in_ready_o}, 64'd0);
        held = result_o;
        repeat (3) begin
          @(posedge clk); #1;
          check("bp_valid_hold", {63'd0, out_valid_o}, 64'd1);
          check("bp_result_stable", {32'd0, result_o}, {32'd0, held});
        end
        out_ready_i = 1'b1;
        hs0 = hs_count;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drain_count", 64'(hs_count - hs0), 64'd4);
        check("bp_drain_idle", {63'd0, out_valid_o}, 64'd0);
      end
    join
    @(posedge clk); #1;

    // Flush: A in stage 1, B presented with flush; neither may emerge.
    send(64'hAAAA, 64'h1, 1'b0, 5'd1);
    sum_i = 64'hBBBB; carry_i = 64'h2; tag_i = 5'd2; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_quiet", {63'd0, out_valid_o}, 64'd0);
    end
    do_op("after_flush", 64'h0000_0001_0000_0002, 64'h3, 1'b1, 5'd3, 32'h1);
    @(posedge clk); #1;

    // Asynchronous reset between edges with work in flight.
    out_ready_i = 1'b0;
    sum_i = 64'h1234; carry_i = 64'h5; tag_i = 5'd4; in_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("arst_result", {32'd0, result_o}, 64'd0);
    check("arst_tag", {59'd0, tag_o}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready_o}, 64'd1);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    // Random stream against the model.
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      sum_i       = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                 : {$urandom, $urandom};
      carry_i     = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                 : {$urandom, $urandom};
      sel_high_i  = $urandom_range(0, 1) != 0;
      tag_i       = 5'($urandom);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(q.size()), 64'd0);
    check("final_idle", {63'd0, out_valid_o}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
